// File: rtl/tt_pkg.sv
// Shared state encodings, gate_id codes and 2-input reference truth tables
// for the truth table learner.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_LEARN = 2'd0,
    ST_DONE  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [2:0] GID_NONE  = 3'd0;
  localparam logic [2:0] GID_AND   = 3'd1;
  localparam logic [2:0] GID_OR    = 3'd2;
  localparam logic [2:0] GID_XOR   = 3'd3;
  localparam logic [2:0] GID_NAND  = 3'd4;
  localparam logic [2:0] GID_NOR   = 3'd5;
  localparam logic [2:0] GID_XNOR  = 3'd6;
  localparam logic [2:0] GID_OTHER = 3'd7;

  // Bit i of each table is the output for input {a,b} == i.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  function automatic logic [2:0] classify(input logic [3:0] tbl);
    case (tbl)
      TT_AND:  classify = GID_AND;
      TT_OR:   classify = GID_OR;
      TT_XOR:  classify = GID_XOR;
      TT_NAND: classify = GID_NAND;
      TT_NOR:  classify = GID_NOR;
      TT_XNOR: classify = GID_XNOR;
      default: classify = GID_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/truth_table_learner_gate_classifier.sv
// Maps a learned 2-input truth table to a gate_id; GID_NONE until the
// table is complete and consistent.
module gate_classifier
  import tt_pkg::*;
(
  input  logic [3:0] tbl,
  input  logic       vld,
  output logic [2:0] gate_id
);

  always_comb begin
    gate_id = GID_NONE;
    if (vld) gate_id = classify(tbl);
  end

endmodule

// File: rtl/truth_table_learner.sv
// Reconstructs a combinational gate's truth table from observed samples,
// flags conflicting responses and classifies 2-input gates.
module truth_table_learner
  import tt_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic                 clr,
  input  logic                 smp_valid,
  input  logic [N_IN-1:0]      smp_in,
  input  logic                 smp_out,
  output logic [2**N_IN-1:0]   table_o,
  output logic [2**N_IN-1:0]   seen_o,
  output logic [N_IN:0]        seen_cnt,
  output logic [CNT_W-1:0]     n_samples,
  output logic                 done,
  output logic                 fault,
  output logic [N_IN-1:0]      fault_idx,
  output logic [2:0]           gate_id
);

  localparam int          DEPTH   = 2**N_IN;
  localparam logic [N_IN:0] FULL  = DEPTH[N_IN:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t        state;
  logic [N_IN:0] cnt_inc;

  assign cnt_inc = seen_cnt + 1'b1;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state     <= ST_LEARN;
      table_o   <= '0;
      seen_o    <= '0;
      seen_cnt  <= '0;
      n_samples <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      fault_idx <= '0;
    end else if (clr) begin
      // clr outranks a coincident sample, which is dropped entirely
      state     <= ST_LEARN;
      table_o   <= '0;
      seen_o    <= '0;
      seen_cnt  <= '0;
      n_samples <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      fault_idx <= '0;
    end else if (smp_valid) begin
      if (n_samples != CNT_MAX) n_samples <= n_samples + 1'b1;
      if (state != ST_FAULT) begin
        if (!seen_o[smp_in]) begin
          table_o[smp_in] <= smp_out;
          seen_o[smp_in]  <= 1'b1;
          seen_cnt        <= cnt_inc;
          if (cnt_inc == FULL) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end else if (table_o[smp_in] != smp_out) begin
          // first value is kept; only the first conflicting index is recorded
          state     <= ST_FAULT;
          fault     <= 1'b1;
          fault_idx <= smp_in;
          done      <= 1'b0;
        end
      end
    end
  end

  generate
    if (N_IN == 2) begin : g_cls
      gate_classifier u_cls (
        .tbl     (table_o),
        .vld     (done),
        .gate_id (gate_id)
      );
    end else begin : g_nocls
      assign gate_id = GID_NONE;
    end
  endgenerate

endmodule
